// File: rtl/chunked_addsub_if.sv
// Request/response bundle for the chunked add/subtract unit.
// The requester drives operands and start; the unit returns status and result.
interface chunked_addsub_if #(
    parameter int N = 32
);
    logic         start_i;
    logic         sub_i;
    logic [N-1:0] A_i;
    logic [N-1:0] B_i;
    logic         Bin_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] S_o;
    logic         Bout_o;
    logic         V_o;
    logic         Z_o;

    modport master (
        output start_i, sub_i, A_i, B_i, Bin_i,
        input  busy_o, done_o, S_o, Bout_o, V_o, Z_o
    );

    modport slave (
        input  start_i, sub_i, A_i, B_i, Bin_i,
        output busy_o, done_o, S_o, Bout_o, V_o, Z_o
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: processes an N-bit operand pair K bits per clock,
// least significant chunk first, with the borrow/carry registered between chunks.
// Results and flags update together on the final chunk and hold until the next
// completion or reset.
module chunked_addsub #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    chunked_addsub_if.slave bus
);
    localparam int L  = N / K;
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic            sub_r;
    logic            cy_r;
    logic [CW-1:0]   idx_r;
    logic [N-1:0]    acc_r;
    logic [N-1:0]    s_r;
    logic            bout_r;
    logic            v_r;
    logic            z_r;
    logic            busy_r;
    logic            done_r;

    int              base_s;
    logic [K-1:0]    a_c_s;
    logic [K-1:0]    b_c_s;
    logic [K:0]      ext_s;
    logic [N-1:0]    acc_s;
    logic            v_s;

    // Chunk datapath: one K-bit add or subtract at the current chunk index,
    // merged into the accumulator, plus the overflow flag for the final result.
    always_comb begin
        base_s = int'(idx_r) * K;
        a_c_s  = a_r[base_s +: K];
        b_c_s  = b_r[base_s +: K];
        if (sub_r) begin
            // Bit K of the widened difference is set exactly when a < b + borrow.
            ext_s = {1'b0, a_c_s} - {1'b0, b_c_s} - {{K{1'b0}}, cy_r};
        end else begin
            ext_s = {1'b0, a_c_s} + {1'b0, b_c_s} + {{K{1'b0}}, cy_r};
        end
        acc_s = acc_r;
        acc_s[base_s +: K] = ext_s[K-1:0];
        if (sub_r) begin
            v_s = (a_r[N-1] != b_r[N-1]) && (acc_s[N-1] != a_r[N-1]);
        end else begin
            v_s = (a_r[N-1] == b_r[N-1]) && (acc_s[N-1] != a_r[N-1]);
        end
    end

    // Next-state logic: accept start from IDLE or DONE, leave BUSY after the last chunk.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (idx_r == LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operand latch, chunk sequencing and registered results/flags.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
            a_r     <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            sub_r   <= 1'b0;
            cy_r    <= 1'b0;
            idx_r   <= {CW{1'b0}};
            acc_r   <= {N{1'b0}};
            s_r     <= {N{1'b0}};
            bout_r  <= 1'b0;
            v_r     <= 1'b0;
            z_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_BUSY);
            done_r  <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i) begin
                        a_r   <= bus.A_i;
                        b_r   <= bus.B_i;
                        sub_r <= bus.sub_i;
                        cy_r  <= bus.Bin_i;
                        idx_r <= {CW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    acc_r <= acc_s;
                    cy_r  <= ext_s[K];
                    idx_r <= idx_r + ONE;
                    if (idx_r == LAST) begin
                        s_r    <= acc_s;
                        bout_r <= ext_s[K];
                        v_r    <= v_s;
                        z_r    <= (acc_s == {N{1'b0}});
                    end
                end
                default: begin
                    idx_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
    assign bus.S_o    = s_r;
    assign bus.Bout_o = bout_r;
    assign bus.V_o    = v_r;
    assign bus.Z_o    = z_r;
endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Multi-cycle, parametrised add/subtract unit with borrow/carry in and out.
- Processes an N-bit operand pair K bits per clock, least significant chunk first, and registers the borrow/carry between chunks.
- Generalises the single-cycle combinational subtractor: adds a mode select, status flags and a start/done handshake.
- Sits beside the ALU for wide or area-constrained arithmetic. K=N gives a one-cycle registered add/sub.

Parameters:
- N, 32, operand and result width; must be a multiple of K.
- K, 8, bits processed per cycle. Latency is L = N/K cycles.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled on a rising edge while not busy.
- sub_i  in  1  mode: 1 = subtract, 0 = add; latched with the operands.
- A_i  in  N  operand A; latched at accepted start.
- B_i  in  N  operand B; latched at accepted start.
- Bin_i  in  1  borrow-in (sub) or carry-in (add); latched at accepted start.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse when the result registers update.
- S_o  out  N  result.
- Bout_o  out  1  borrow-out (sub) or carry-out (add).
- V_o  out  1  signed two's-complement overflow.
- Z_o  out  1  result equals zero.

Behaviour:
- Reset (rstn_i low, any time, including mid-operation):
  - all outputs and internal state go to 0 immediately; FSM goes to IDLE.
  - An in-flight operation is discarded and produces no done_o after release.
- FSM states: IDLE, BUSY, DONE.
- Transitions:
  - IDLE/DONE with start_i=1 → BUSY: latch A_i, B_i, sub_i, Bin_i; chunk index = 0; internal borrow/carry = Bin_i.
  - IDLE/DONE with start_i=0 → IDLE.
  - BUSY, chunk index < L-1 → BUSY; chunk index increments.
  - BUSY, chunk index = L-1 → DONE.
- start_i while BUSY is ignored; latched operands are unaffected by later input changes.
- Per BUSY cycle, at chunk index c, on bits [cK+K-1 : cK]:
  - sub: d = a - b - borrow; chunk result = d mod 2^K; next borrow = 1 when a < b + borrow (unsigned).
  - add: s = a + b + carry; chunk result = s mod 2^K; next carry = bit K of s.
  - The chunk result goes to an internal accumulator, not to S_o.
- Completion edge (BUSY → DONE), all updated together:
  - S_o ← accumulator with final chunk.
  - Bout_o ← final borrow/carry.
  - Z_o ← (S_o == 0).
  - V_o ← add: A[N-1]==B[N-1] and S[N-1]!=A[N-1]; sub: A[N-1]!=B[N-1] and S[N-1]!=A[N-1].
- Handshake and timing:
  - busy_o = 1 exactly in BUSY: L cycles after the accepting edge.
  - done_o = 1 exactly in DONE, one cycle; DONE falls to IDLE or BUSY on the next edge.
  - Start accepted at edge t → results and done_o visible after edge t+L.
  - K=N: L=1, one BUSY cycle.
- S_o, Bout_o, V_o, Z_o hold their value from the last completion until the next completion or reset.
- Back-to-back: start_i=1 while in DONE is accepted; busy_o rises on the edge after done_o; throughput is one operation per L+1 cycles.
- Bin_i=1 with all-zero operands, sub: S_o = all ones, Bout_o = 1. No special case.

Test Plan:
- Reset mid-op: assert rstn_i low two cycles after a start → all outputs 0 immediately; no done_o after release; a new start then completes normally.
- sub, A=0x12345678, B=0xFEDCBA98, Bin=0 → done_o 4 cycles after start; S_o=0x13579BE0, Bout_o=1, V_o=0, Z_o=0. Same with Bin=1 → S_o=0x13579BDF.
- sub, A=0xFEDCBA98, B=0x12345678 → S_o=0xECA86420, Bout_o=0, V_o=0. Then A=0x00000098, B=0xFFFFFFD6 → S_o=0x000000C2, Bout_o=1.
- sub, A=1, B=1, Bin=0 → S_o=0, Z_o=1, Bout_o=0. Bin=1 → S_o=0xFFFFFFFF, Bout_o=1, Z_o=0.
- add, 0x7FFFFFFF+1 → S_o=0x80000000, V_o=1, Bout_o=0. 0xFFFFFFFF+1 → S_o=0, Z_o=1, Bout_o=1, V_o=0.
- Protocol:
  - start_i held high continuously → done_o pulses every 5 cycles.
  - start_i pulsed while busy_o=1 with changed operands → ignored; result reflects the original operands.
  - Repeat the 0x12345678-0xFEDCBA98 case with K=32 (L=1) and K=4 (L=8) → same values, matching latency.
